// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, buffer entry layout and
// the instruction field positions the decoder also relies on.
package mips_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} pairs; flush wins over push.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // a full buffer still accepts a push when the head leaves in the same cycle
    do_push  = push && ((count_q != FULL) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: drives the imem req/ack handshake, owns the
// fetch PC, buffers returned words and handles redirects from execute.
//
//   state   | meaning
//   IDLE    | no request; waiting for buffer room
//   REQ     | request out at fetch_pc
//   DISCARD | request for a pre-redirect address still in flight; its data is dropped
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic [5:0]         out_op,
  output logic [5:0]         out_funct
);

  localparam int               CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_after_pop;
  logic             ack, pop, push, flush;
  fetch_entry_t     head, push_entry;

  assign imem_req      = (state_q != IDLE);
  assign imem_addr     = addr_q;
  assign ack           = imem_req && imem_ack;
  assign out_valid     = (count != '0);
  assign pop           = out_valid && out_ready;
  assign cnt_after_pop = count - CNT_W'(pop);
  assign push_entry    = '{pc: fetch_pc_q, instr: imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc & ~32'h3;
      // an unacked request cannot be withdrawn, so wait out its ack in DISCARD
      if ((state_q != IDLE) && !ack) begin
        state_d = DISCARD;
      end else begin
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_after_pop < DEPTH) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = ((cnt_after_pop + CNT_W'(1)) < DEPTH) ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (ack) begin
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // DISCARD keeps presenting the stale address until its ack
    if (state_d != DISCARD) begin
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head       (head)
  );

  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_op    = out_instr[OP_MSB:OP_LSB];
  assign out_funct = out_instr[FUNCT_MSB:FUNCT_LSB];

endmodule
